sum_history_unit: RTL and testbench
===================================

# sum_history_unit

Parametrised add/subtract unit with a registered result and an on-chip history ring buffer of the last DEPTH results, readable by age. It is the SimpleCPU successor to the 2-bit combinational summer. It adds configurable width, subtraction, a valid/ready request handshake, carry/borrow capture and result logging. It sits beside the ALU, so the control unit can issue sums and later read back recent results for debug or trace.

## Interface
- WIDTH, 8, operand width in bits (≥1)
- DEPTH, 10, history entries (≥2, need not be a power of two)
- IDX_W, $clog2(DEPTH), derived localparam; not overridable

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  1  operation request
- req_ready  out  1  unit can accept a request this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  0 = A+B, 1 = A−B
- result  out  WIDTH+1  registered result; MSB = carry (add) or borrow (sub)
- result_valid  out  1  one-cycle pulse when result updates
- clear  in  1  synchronous history flush
- hist_rd_en  in  1  history read request
- hist_rd_idx  in  IDX_W  age of entry to read: 0 = newest
- hist_rd_data  out  WIDTH+1  read data
- hist_rd_valid  out  1  read returned a stored entry
- hist_count  out  IDX_W+1  number of valid history entries, 0..DEPTH

## Operation
- A request is accepted when req_valid && req_ready.
- req_ready = !clear. It is combinational from clear only and is never gated by history fullness.
- Add: result = {1'b0,a} + {1'b0,b}.
- Sub: result = ({1'b0,a} − {1'b0,b}) mod 2^(WIDTH+1). MSB = 1 when a < b.
- Each accept writes the new result into the ring buffer at wr_ptr.
  - wr_ptr increments and wraps from DEPTH−1 to 0.
  - hist_count increments and saturates at DEPTH.
  - Once full, the oldest entry is overwritten.
- History read:
  - Physical index = (wr_ptr − 1 − hist_rd_idx) mod DEPTH, with wr_ptr sampled in the read cycle.
  - If hist_rd_idx ≥ hist_count: hist_rd_data = 0, hist_rd_valid = 0.
- clear: wr_ptr ← 0 and hist_count ← 0. Buffer contents need not be zeroed.
  - result and result_valid are unaffected except that no accept occurs.
- The result path is a two-state FSM:
  - IDLE: no result pending.
  - DONE: result_valid high.
  - An accept in either state moves to DONE next cycle.
  - No accept moves to IDLE.
  - Back-to-back accepts keep result_valid high every cycle.

## Timing
- Reset values: result = 0, result_valid = 0, hist_rd_data = 0, hist_rd_valid = 0, hist_count = 0, wr_ptr = 0, FSM = IDLE. req_ready follows clear (1 during reset, since clear is input-driven).
- Result latency: accept at edge N → result and result_valid valid after edge N, for one cycle per accept.
- History write takes effect at the accept edge. hist_count reflects it the cycle after the accept.
- Read latency is 1 cycle: hist_rd_en sampled at edge N → hist_rd_data and hist_rd_valid valid after edge N.
  - Without hist_rd_en, hist_rd_valid ← 0 and hist_rd_data holds.
- Read and accept in the same cycle: read-before-write. The read uses the pre-accept wr_ptr and hist_count.
- Read and clear in the same cycle: the read uses the pre-clear state.
- Reset mid-operation: everything returns to reset values immediately. The history is treated as empty.

## Structure
- Package sum_pkg:
  - op encoding constants OP_ADD = 1'b0, OP_SUB = 1'b1
  - FSM state typedef {S_IDLE, S_DONE}
  - function ptr_wrap(ptr, depth) for modular increment and decrement
- Sub-module sum_history: holds the DEPTH×(WIDTH+1) ring buffer, wr_ptr, hist_count and the age-indexed registered read port.
- The top level holds the arithmetic, handshake and FSM.

## Test plan
All cases use WIDTH=8, DEPTH=10.
- Reset with rst_n low mid-stream → all outputs 0 within the same cycle; hist_count = 0; a read of idx 0 gives hist_rd_valid = 0.
- Add a=200, b=100 → result = 9'h12C (carry=1), result_valid pulse 1 cycle later. Sub a=5, b=7 → result = 9'h1FE (borrow=1).
- 12 back-to-back adds with a=k, b=0 for k=1..12 → result_valid high 12 consecutive cycles; hist_count = 10. Reads of idx 0 and idx 9 → 12 and 3; idx 9 is valid.
- After 3 accepts, read idx 3 → hist_rd_valid = 0, data 0. Read idx 2 → the first result.
- Same cycle: accept (a=1, b=1) and read idx 0 with previous newest = 7 → data 7. The next read of idx 0 → 2.
- clear asserted together with req_valid → req_ready = 0, no result_valid, hist_count = 0. The next accept lands at age 0 with count 1.

Source files
------------

// File: rtl/sum_pkg.sv
// sum_pkg: shared definitions for the sum_history_unit slice.
//   OP_ADD / OP_SUB : encoding of the 'sub' operation select input
//   state_t         : result-path FSM states
//   ptr_wrap        : folds a ring-buffer pointer back into 0..depth-1
package sum_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic {
    S_IDLE,
    S_DONE
  } state_t;

  // Modular fold for a pointer that has been stepped up or down.
  // Only one correction is applied, so the argument must lie in
  // [-depth, 2*depth). Increments (ptr+1) and age lookups
  // (ptr-1-idx with idx < depth) both stay inside that window.
  function automatic int ptr_wrap(input int ptr, input int depth);
    int r;
    r = ptr;
    if (r < 0) begin
      r = r + depth;
    end else if (r >= depth) begin
      r = r - depth;
    end
    return r;
  endfunction

endpackage

// File: rtl/sum_history.sv
// sum_history: ring buffer of the last DEPTH results with an age-indexed,
// registered read port.
//   clk, rst_n      clock, asynchronous active-low reset
//   wr_en, wr_data  store wr_data at wr_ptr (one accepted result)
//   clear           synchronous flush: wr_ptr and count return to 0
//   rd_en, rd_idx   read request; rd_idx is the age, 0 = newest
//   rd_data         registered read data (0 when the age is not stored)
//   rd_valid        registered: the read returned a stored entry
//   count           number of valid entries, 0..DEPTH
module sum_history
  import sum_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 10,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH:0]   wr_data,
  input  logic             clear,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH:0]   rd_data,
  output logic             rd_valid,
  output logic [IDX_W:0]   count
);

  logic [WIDTH:0]   mem [DEPTH];
  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] wr_ptr_next;
  logic [IDX_W-1:0] rd_phys;
  logic             rd_hit;

  // Both lookups use the registered (pre-edge) wr_ptr and count, which
  // gives read-before-write when a read and an accept/clear coincide.
  always_comb begin
    wr_ptr_next = IDX_W'(ptr_wrap(int'(wr_ptr) + 1, DEPTH));
    rd_phys     = IDX_W'(ptr_wrap(int'(wr_ptr) - 1 - int'(rd_idx), DEPTH));
    rd_hit      = ({1'b0, rd_idx} < count);
  end

  // Storage carries no reset; an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (wr_en && !clear) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr_next;
      if (count != (IDX_W + 1)'(DEPTH)) begin
        count <= count + 1'b1;
      end
    end
  end

  // Without rd_en the data register holds its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (rd_en) begin
      rd_valid <= rd_hit;
      rd_data  <= rd_hit ? mem[rd_phys] : '0;
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sum_history_unit.sv
// sum_history_unit: add/subtract unit with a registered result and a
// history of the last DEPTH results readable by age.
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid, req_ready  request handshake (see below)
//   a, b, sub             operands; sub = OP_SUB selects a-b
//   result                registered {carry/borrow, sum}
//   result_valid          high the cycle after every accept
//   clear                 synchronous history flush
//   hist_rd_en/idx        history read request, idx 0 = newest
//   hist_rd_data/valid    registered history read response
//   hist_count            number of valid history entries
//
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both high. req_ready depends only on clear (low while a
// flush is in progress) and never on history fullness; the requester may
// change a/b/sub freely when no accept takes place.
module sum_history_unit
  import sum_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 10,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH:0]   result,
  output logic             result_valid,
  input  logic             clear,
  input  logic             hist_rd_en,
  input  logic [IDX_W-1:0] hist_rd_idx,
  output logic [WIDTH:0]   hist_rd_data,
  output logic             hist_rd_valid,
  output logic [IDX_W:0]   hist_count
);

  state_t         state;
  state_t         state_next;
  logic           accept;
  logic [WIDTH:0] op_result;

  assign req_ready = !clear;
  assign accept    = req_valid && req_ready;

  // The extra MSB is the carry for an add; for a subtract the wrap-around
  // of the (WIDTH+1)-bit difference sets it exactly when a < b (borrow).
  always_comb begin
    if (sub == OP_SUB) begin
      op_result = {1'b0, a} - {1'b0, b};
    end else begin
      op_result = {1'b0, a} + {1'b0, b};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      result <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        result <= op_result;
      end
    end
  end

  // Every accept lands in DONE; any cycle without one drops back to IDLE,
  // so back-to-back accepts keep result_valid high continuously.
  always_comb begin
    state_next   = S_IDLE;
    result_valid = 1'b0;
    if (accept) begin
      state_next = S_DONE;
    end
    if (state == S_DONE) begin
      result_valid = 1'b1;
    end
  end

  sum_history #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_history (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (accept),
    .wr_data  (op_result),
    .clear    (clear),
    .rd_en    (hist_rd_en),
    .rd_idx   (hist_rd_idx),
    .rd_data  (hist_rd_data),
    .rd_valid (hist_rd_valid),
    .count    (hist_count)
  );

endmodule

// File: tb/tb_sum_history_unit.sv
module tb_sum_history_unit;

  localparam int WIDTH = 8;
  localparam int DEPTH = 10;
  localparam int IDX_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic [WIDTH:0]   result;
  logic             result_valid;
  logic             clear;
  logic             hist_rd_en;
  logic [IDX_W-1:0] hist_rd_idx;
  logic [WIDTH:0]   hist_rd_data;
  logic             hist_rd_valid;
  logic [IDX_W:0]   hist_count;

  sum_history_unit #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .a             (a),
    .b             (b),
    .sub           (sub),
    .result        (result),
    .result_valid  (result_valid),
    .clear         (clear),
    .hist_rd_en    (hist_rd_en),
    .hist_rd_idx   (hist_rd_idx),
    .hist_rd_data  (hist_rd_data),
    .hist_rd_valid (hist_rd_valid),
    .hist_count    (hist_count)
  );

  // ---------------- scoreboard state ----------------
  logic [WIDTH:0] exp_q[$];   // expected results, in accept order
  logic [WIDTH:0] hist_m[$];  // history model, front = newest
  logic [WIDTH:0] exp_rd_data = '0;
  logic           exp_rd_valid = 1'b0;
  int             pass_cnt = 0;
  int             total_cnt = 0;

  function automatic logic [WIDTH:0] model_op(input logic [WIDTH-1:0] aa,
                                              input logic [WIDTH-1:0] bb,
                                              input logic s);
    logic [WIDTH:0] ea;
    logic [WIDTH:0] eb;
    ea = {1'b0, aa};
    eb = {1'b0, bb};
    return s ? (ea - eb) : (ea + eb);
  endfunction

  // Result monitor: every result_valid cycle must match the oldest
  // outstanding expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && result_valid === 1'b1) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_result: got %h, none expected", result);
      end else begin
        logic [WIDTH:0] e;
        e = exp_q.pop_front();
        if (result !== e) $display("FAIL sb_result: got %h expected %h", result, e);
        else pass_cnt++;
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a falling edge: drives one cycle of inputs, updates the
  // scoreboard and history model (read computed before the write/clear),
  // and returns at the next falling edge with the inputs back to idle.
  task automatic drive_cycle(input logic v, input logic [WIDTH-1:0] aa,
                             input logic [WIDTH-1:0] bb, input logic s,
                             input logic c, input logic re,
                             input logic [IDX_W-1:0] ri);
    logic [WIDTH:0] e;
    req_valid   = v;
    a           = aa;
    b           = bb;
    sub         = s;
    clear       = c;
    hist_rd_en  = re;
    hist_rd_idx = ri;
    if (re) begin
      if (int'(ri) < hist_m.size()) begin
        exp_rd_data  = hist_m[ri];
        exp_rd_valid = 1'b1;
      end else begin
        exp_rd_data  = '0;
        exp_rd_valid = 1'b0;
      end
    end else begin
      exp_rd_valid = 1'b0;
    end
    if (c) begin
      hist_m.delete();
    end else if (v) begin
      e = model_op(aa, bb, s);
      exp_q.push_back(e);
      hist_m.push_front(e);
      if (hist_m.size() > DEPTH) void'(hist_m.pop_back());
    end
    @(negedge clk);
    req_valid  = 1'b0;
    clear      = 1'b0;
    hist_rd_en = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    req_valid = 1'b0; a = '0; b = '0; sub = 1'b0;
    clear = 1'b0; hist_rd_en = 1'b0; hist_rd_idx = '0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (result !== 9'h000) $display("FAIL rst_result: got %h expected 000", result);
    else pass_cnt++;
    total_cnt++;
    if (result_valid !== 1'b0) $display("FAIL rst_result_valid: got %b expected 0", result_valid);
    else pass_cnt++;
    total_cnt++;
    if (hist_count !== 5'd0) $display("FAIL rst_hist_count: got %0d expected 0", hist_count);
    else pass_cnt++;
    total_cnt++;
    if (hist_rd_valid !== 1'b0 || hist_rd_data !== 9'h000)
      $display("FAIL rst_rd: got valid %b data %h expected 0/000", hist_rd_valid, hist_rd_data);
    else pass_cnt++;
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b expected 1", req_ready);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_sub;
    drive_cycle(1'b1, 8'd200, 8'd100, 1'b0, 1'b0, 1'b0, '0);
    total_cnt++;
    if (result_valid !== 1'b1 || result !== 9'h12C)
      $display("FAIL add_carry: got valid %b result %h expected 1/12c", result_valid, result);
    else pass_cnt++;
    drive_cycle(1'b1, 8'd5, 8'd7, 1'b1, 1'b0, 1'b0, '0);
    total_cnt++;
    if (result_valid !== 1'b1 || result !== 9'h1FE)
      $display("FAIL sub_borrow: got valid %b result %h expected 1/1fe", result_valid, result);
    else pass_cnt++;
    drive_cycle(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, '0);
    total_cnt++;
    if (result_valid !== 1'b0 || result !== 9'h1FE)
      $display("FAIL idle_after_pulse: got valid %b result %h expected 0/1fe", result_valid, result);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int streak;
    streak = 0;
    for (int k = 1; k <= 12; k++) begin
      drive_cycle(1'b1, 8'(k), 8'd0, 1'b0, 1'b0, 1'b0, '0);
      if (result_valid === 1'b1) streak++;
    end
    total_cnt++;
    if (streak != 12) $display("FAIL b2b_valid_streak: got %0d cycles expected 12", streak);
    else pass_cnt++;
    total_cnt++;
    if (hist_count !== 5'd10) $display("FAIL b2b_count_sat: got %0d expected 10", hist_count);
    else pass_cnt++;
    drive_cycle(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 4'd0);
    total_cnt++;
    if (hist_rd_valid !== 1'b1 || hist_rd_data !== 9'd12)
      $display("FAIL b2b_read_idx0: got valid %b data %0d expected 1/12", hist_rd_valid, hist_rd_data);
    else pass_cnt++;
    drive_cycle(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 4'd9);
    total_cnt++;
    if (hist_rd_valid !== 1'b1 || hist_rd_data !== 9'd3)
      $display("FAIL b2b_read_idx9: got valid %b data %0d expected 1/3", hist_rd_valid, hist_rd_data);
    else pass_cnt++;
    drive_cycle(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, '0);
    total_cnt++;
    if (hist_rd_valid !== 1'b0 || hist_rd_data !== 9'd3)
      $display("FAIL rd_hold: got valid %b data %0d expected 0/3", hist_rd_valid, hist_rd_data);
    else pass_cnt++;
  endtask

  task automatic test_count_boundary;
    drive_cycle(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, '0);
    drive_cycle(1'b1, 8'd10, 8'd1, 1'b0, 1'b0, 1'b0, '0);
    drive_cycle(1'b1, 8'd20, 8'd1, 1'b0, 1'b0, 1'b0, '0);
    drive_cycle(1'b1, 8'd30, 8'd1, 1'b0, 1'b0, 1'b0, '0);
    total_cnt++;
    if (hist_count !== 5'd3) $display("FAIL bnd_count: got %0d expected 3", hist_count);
    else pass_cnt++;
    drive_cycle(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 4'd3);
    total_cnt++;
    if (hist_rd_valid !== 1'b0 || hist_rd_data !== 9'd0)
      $display("FAIL bnd_read_idx3: got valid %b data %0d expected 0/0", hist_rd_valid, hist_rd_data);
    else pass_cnt++;
    drive_cycle(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 4'd2);
    total_cnt++;
    if (hist_rd_valid !== 1'b1 || hist_rd_data !== 9'd11)
      $display("FAIL bnd_read_idx2: got valid %b data %0d expected 1/11", hist_rd_valid, hist_rd_data);
    else pass_cnt++;
  endtask

  task automatic test_read_during_accept;
    drive_cycle(1'b1, 8'd3, 8'd4, 1'b0, 1'b0, 1'b0, '0);
    drive_cycle(1'b1, 8'd1, 8'd1, 1'b0, 1'b0, 1'b1, 4'd0);
    total_cnt++;
    if (hist_rd_valid !== 1'b1 || hist_rd_data !== 9'd7)
      $display("FAIL rbw_read: got valid %b data %0d expected 1/7", hist_rd_valid, hist_rd_data);
    else pass_cnt++;
    drive_cycle(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 4'd0);
    total_cnt++;
    if (hist_rd_valid !== 1'b1 || hist_rd_data !== 9'd2)
      $display("FAIL rbw_next_read: got valid %b data %0d expected 1/2", hist_rd_valid, hist_rd_data);
    else pass_cnt++;
  endtask

  task automatic test_clear_with_req;
    // Manual drive: the clear blocks the accept, so nothing is expected.
    req_valid = 1'b1; a = 8'd9; b = 8'd9; sub = 1'b0; clear = 1'b1;
    #1;
    total_cnt++;
    if (req_ready !== 1'b0) $display("FAIL clr_req_ready: got %b expected 0", req_ready);
    else pass_cnt++;
    hist_m.delete();
    @(negedge clk);
    req_valid = 1'b0;
    clear = 1'b0;
    total_cnt++;
    if (result_valid !== 1'b0 || hist_count !== 5'd0)
      $display("FAIL clr_no_accept: got valid %b count %0d expected 0/0", result_valid, hist_count);
    else pass_cnt++;
    drive_cycle(1'b1, 8'd4, 8'd5, 1'b0, 1'b0, 1'b0, '0);
    total_cnt++;
    if (hist_count !== 5'd1) $display("FAIL clr_count_after: got %0d expected 1", hist_count);
    else pass_cnt++;
    drive_cycle(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 4'd0);
    total_cnt++;
    if (hist_rd_valid !== 1'b1 || hist_rd_data !== 9'd9)
      $display("FAIL clr_read_idx0: got valid %b data %0d expected 1/9", hist_rd_valid, hist_rd_data);
    else pass_cnt++;
  endtask

  task automatic test_random;
    int errs;
    errs = 0;
    for (int i = 0; i < 60; i++) begin
      drive_cycle(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)));
      total_cnt++;
      if (hist_rd_valid !== exp_rd_valid || hist_rd_data !== exp_rd_data)
        $display("FAIL rnd_read[%0d]: got valid %b data %h expected %b/%h",
                 i, hist_rd_valid, hist_rd_data, exp_rd_valid, exp_rd_data);
      else pass_cnt++;
      total_cnt++;
      if (int'(hist_count) != hist_m.size())
        $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, hist_count, hist_m.size());
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid;
    drive_cycle(1'b1, 8'd50, 8'd50, 1'b0, 1'b0, 1'b0, '0);
    // Second accept is killed by reset before its result is observed.
    req_valid = 1'b1; a = 8'd60; b = 8'd1; sub = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    req_valid = 1'b0;
    exp_q.delete();
    hist_m.delete();
    exp_rd_data = '0;
    total_cnt++;
    if (result !== 9'h000 || result_valid !== 1'b0)
      $display("FAIL mid_rst_result: got valid %b result %h expected 0/000", result_valid, result);
    else pass_cnt++;
    total_cnt++;
    if (hist_count !== 5'd0 || hist_rd_valid !== 1'b0 || hist_rd_data !== 9'h000)
      $display("FAIL mid_rst_hist: got count %0d valid %b data %h expected 0/0/000",
               hist_count, hist_rd_valid, hist_rd_data);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive_cycle(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 4'd0);
    total_cnt++;
    if (hist_rd_valid !== 1'b0 || hist_rd_data !== 9'h000)
      $display("FAIL mid_rst_read_idx0: got valid %b data %h expected 0/000", hist_rd_valid, hist_rd_data);
    else pass_cnt++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_add_sub();
    test_back_to_back();
    test_count_boundary();
    test_read_during_accept();
    test_clear_with_req();
    test_random();
    drive_cycle(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, '0);
    test_reset_mid();
    drive_cycle(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, '0);
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL sb_drain: %0d results never produced", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
